mem_port_arbiter: RTL and testbench

//  Shares the single external memory port (mem_valid/mem_ready, addr/wdata/wstrb/rdata) between two requesters:
//  m0 = multicycle datapath (fetch/load/store/AMO), m1 = secondary master (DMA / page walker).

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_arbiter_watchdog.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 tb/tb_mem_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-master memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

    localparam logic [31:0] ARB_ERR_RDATA       = 32'hDEAD_BEEF;
    localparam int unsigned ARB_TIMEOUT_DEFAULT = 1024;

    // last_m1 = 1 means m1 was served last, so m0 wins a tie.
    function automatic arb_state_e arb_pick(input logic v0, input logic v1, input logic last_m1);
        arb_state_e s;
        s = ARB_IDLE;
        if (v0 && v1) begin
            s = last_m1 ? ARB_GNT0 : ARB_GNT1;
        end else if (v0) begin
            s = ARB_GNT0;
        end else if (v1) begin
            s = ARB_GNT1;
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear, saturating at TIMEOUT_CYCLES-1.
// TIMEOUT_CYCLES = 0 removes the counter entirely and expire stays low.
module mem_port_arbiter_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int unsigned   CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] count_q;
            logic [CW-1:0] count_d;

            always_comb begin
                count_d = count_q;
                if (clear) begin
                    count_d = '0;
                end else if (enable && (count_q != LAST)) begin
                    count_d = count_q + CW'(1);
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign expire = enable && (count_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the single external memory port, grant held per transaction.
// Define ARB_CPU_PRIO_EN for fixed m0 priority; default build is round-robin.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
    parameter logic [31:0] ERR_RDATA      = ARB_ERR_RDATA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        timeout_err
);

    arb_state_e  state_q;
    arb_state_e  state_d;
    logic        last_grant_q;
    logic        last_grant_d;
    logic        in_grant;
    logic        gnt0;
    logic        gnt1;
    logic        expire;
    logic [31:0] resp_rdata;

    assign in_grant = (state_q != ARB_IDLE);
    assign gnt0     = (state_q == ARB_GNT0);
    assign gnt1     = (state_q == ARB_GNT1);

    // Counter runs only while a granted access waits; idle holds it at zero.
    mem_port_arbiter_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_grant),
        .enable (in_grant && !mem_ready),
        .expire (expire)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            ARB_IDLE: begin
`ifdef ARB_CPU_PRIO_EN
                state_d = arb_pick(m0_valid, m1_valid, 1'b1);
`else
                state_d = arb_pick(m0_valid, m1_valid, last_grant_q);
`endif
            end
            ARB_GNT0, ARB_GNT1: begin
                if (mem_ready || expire) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = gnt1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // expire is already qualified by !mem_ready, so a same-cycle ready completes normally.
    always_comb begin
        mem_valid   = in_grant;
        mem_addr    = gnt1 ? m1_addr  : m0_addr;
        mem_wdata   = gnt1 ? m1_wdata : m0_wdata;
        mem_wstrb   = in_grant ? (gnt1 ? m1_wstrb : m0_wstrb) : '0;
        resp_rdata  = expire ? ERR_RDATA : mem_rdata;
        m0_ready    = gnt0 && (mem_ready || expire);
        m1_ready    = gnt1 && (mem_ready || expire);
        m0_rdata    = gnt0 ? resp_rdata : '0;
        m1_rdata    = gnt1 ? resp_rdata : '0;
        timeout_err = expire;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random requesters and a random-latency memory,
// expected responses queued per master when the memory commits to a latency.
module tb_mem_port_arbiter;

    localparam int unsigned TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] rdata;
        logic        to;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        timeout_err;

    logic        rv      [2];
    logic [31:0] r_addr  [2];
    logic [31:0] r_wdata [2];
    logic [3:0]  r_wstrb [2];

    int checks = 0;
    int errors = 0;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    logic [31:0] mem_m [int unsigned];

    bit resp_en = 0;
    bit mon_en  = 0;
    bit busy    = 0;
    int owner   = 0;
    int cyc     = 0;
    int end_cyc = 0;
    int k_lat   = 0;
    int last_served = 1;
    bit p0 = 0, p1 = 0;
    logic [31:0] resp_word = '0;

    mem_port_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .ERR_RDATA     (ERR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_valid   (rv[0]),
        .m0_ready   (m0_ready),
        .m0_addr    (r_addr[0]),
        .m0_wdata   (r_wdata[0]),
        .m0_wstrb   (r_wstrb[0]),
        .m0_rdata   (m0_rdata),
        .m1_valid   (rv[1]),
        .m1_ready   (m1_ready),
        .m1_addr    (r_addr[1]),
        .m1_wdata   (r_wdata[1]),
        .m1_wstrb   (r_wstrb[1]),
        .m1_rdata   (m1_rdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int unsigned key;
        key = int'(a[31:2]);
        if (mem_m.exists(key)) return mem_m[key];
        return {a[31:2], 2'b00} ^ 32'h5A5A_3C3C;
    endfunction

    task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = mem_rd(a);
        for (int unsigned b = 0; b < 4; b++) begin
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        mem_m[int'(a[31:2])] = w;
    endtask

    // Memory side: spots new grants, predicts the owner, picks a latency and queues the outcome.
    initial begin
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                busy = 0;
                p0 = 0;
                p1 = 0;
                continue;
            end
            if (busy) begin
                cyc++;
                if (cyc > end_cyc) begin
                    chk(!mem_valid, "valid_drop", {31'b0, mem_valid}, 32'h0);
                    busy = 0;
                end else begin
                    chk(mem_valid && mem_addr == r_addr[owner] && mem_wstrb == r_wstrb[owner],
                        "grant_hold", mem_addr, r_addr[owner]);
                end
            end else if (mem_valid) begin
                exp_t e;
                int sel;
                chk(p0 || p1, "spurious_grant", {31'b0, mem_valid}, 32'h0);
`ifdef ARB_CPU_PRIO_EN
                owner = p0 ? 0 : 1;
`else
                owner = (p0 && p1) ? (last_served == 1 ? 0 : 1) : (p0 ? 0 : 1);
`endif
                chk(mem_addr  == r_addr[owner],  "grant_addr",  mem_addr,  r_addr[owner]);
                chk(mem_wdata == r_wdata[owner], "grant_wdata", mem_wdata, r_wdata[owner]);
                chk(mem_wstrb == r_wstrb[owner], "grant_wstrb", {28'b0, mem_wstrb}, {28'b0, r_wstrb[owner]});
                last_served = owner;
                sel = int'($urandom_range(0, 9));
                if (sel <= 4)      k_lat = int'($urandom_range(1, 3));
                else if (sel == 5) k_lat = TO - 1;
                else if (sel <= 7) k_lat = TO;
                else               k_lat = int'($urandom_range(TO + 1, TO + 4));
                if (k_lat <= TO) begin
                    resp_word = (r_wstrb[owner] == 4'h0) ? mem_rd(r_addr[owner]) : 32'h0;
                    e.rdata = resp_word;
                    e.to    = 1'b0;
                    if (r_wstrb[owner] != 4'h0) mem_wr(r_addr[owner], r_wdata[owner], r_wstrb[owner]);
                    end_cyc = k_lat;
                end else begin
                    e.rdata = ERR;
                    e.to    = 1'b1;
                    end_cyc = TO;
                end
                if (owner == 0) exp_q0.push_back(e);
                else            exp_q1.push_back(e);
                busy = 1;
                cyc  = 1;
            end else begin
                chk(!(p0 || p1), "missing_grant", {31'b0, mem_valid}, 32'h1);
            end
            if (!mem_valid) chk(mem_wstrb == 4'h0, "idle_wstrb", {28'b0, mem_wstrb}, 32'h0);
            p0 = !busy && rv[0];
            p1 = !busy && rv[1];
            mem_ready = busy && (cyc == k_lat);
            mem_rdata = mem_ready ? resp_word : $urandom();
        end
    end

    // Requester side: pops the queue whenever a ready pulse appears.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) continue;
            for (int x = 0; x < 2; x++) begin
                logic        rdy;
                logic [31:0] rd;
                bit          own_now;
                bit          due;
                exp_t        e;
                rdy     = (x == 0) ? m0_ready : m1_ready;
                rd      = (x == 0) ? m0_rdata : m1_rdata;
                own_now = busy && (owner == x);
                due     = own_now && (cyc == end_cyc);
                if (rdy) begin
                    if (!due || (x == 0 ? exp_q0.size() == 0 : exp_q1.size() == 0)) begin
                        chk(1'b0 == rdy, $sformatf("unexpected_ready_m%0d", x), {31'b0, rdy}, 32'h0);
                    end else begin
                        e = (x == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk(rd == e.rdata, $sformatf("rdata_m%0d", x), rd, e.rdata);
                        chk(timeout_err == e.to, $sformatf("timeout_err_m%0d", x),
                            {31'b0, timeout_err}, {31'b0, e.to});
                    end
                end else begin
                    chk(!due, $sformatf("missing_ready_m%0d", x), {31'b0, rdy}, 32'h1);
                    if (!own_now) chk(rd == 32'h0, $sformatf("ungranted_rdata_m%0d", x), rd, 32'h0);
                end
            end
            if (!m0_ready && !m1_ready) chk(!timeout_err, "stray_timeout_err", {31'b0, timeout_err}, 32'h0);
        end
    end

    task automatic requester(input int id, input int n);
        for (int t = 0; t < n; t++) begin
            int unsigned gap;
            int unsigned a;
            int          w;
            logic        got;
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            a = $urandom_range(0, 15);
            r_addr[id]  = 32'h8000_0000 + (a << 2);
            r_wdata[id] = $urandom();
            r_wstrb[id] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            rv[id]      = 1'b1;
            w   = 0;
            got = 1'b0;
            while (!got && w < 200) begin
                @(negedge clk);
                #3;
                got = (id == 0) ? m0_ready : m1_ready;
                w++;
            end
            chk(got, $sformatf("req_complete_m%0d", id), 32'(w), 32'd200);
            @(posedge clk);
            #1;
            rv[id] = 1'b0;
        end
    endtask

    task automatic wait_grant(output bit got);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            #1;
            got = mem_valid;
        end
    endtask

    initial begin
        bit got;
        reset      = 1'b1;
        rv[0]      = 1'b0;
        rv[1]      = 1'b0;
        r_addr[0]  = '0;  r_addr[1]  = '0;
        r_wdata[0] = '0;  r_wdata[1] = '0;
        r_wstrb[0] = '0;  r_wstrb[1] = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        rv[0] = 1'b1;
        rv[1] = 1'b1;
        r_wstrb[0] = 4'hF;
        #1;
        chk(!mem_valid, "reset_mem_valid", {31'b0, mem_valid}, 32'h0);
        chk(mem_wstrb == 4'h0, "reset_mem_wstrb", {28'b0, mem_wstrb}, 32'h0);
        chk(!m0_ready && !m1_ready, "reset_ready", {30'b0, m1_ready, m0_ready}, 32'h0);
        chk(!timeout_err, "reset_timeout_err", {31'b0, timeout_err}, 32'h0);
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        r_wstrb[0] = 4'h0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        resp_en = 1;
        mon_en  = 1;
        fork
            requester(0, 60);
            requester(1, 60);
        join
        repeat (4) @(posedge clk);
        #1;
        chk(exp_q0.size() == 0, "drain_m0", 32'(exp_q0.size()), 32'h0);
        chk(exp_q1.size() == 0, "drain_m1", 32'(exp_q1.size()), 32'h0);
        resp_en = 0;
        mon_en  = 0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // m0 read completes, leaving m1 next in line for a tie.
        rv[0] = 1'b1; r_addr[0] = 32'h0000_0100; r_wstrb[0] = 4'h0;
        wait_grant(got);
        chk(got && mem_addr == 32'h0000_0100, "d_grant_m0", mem_addr, 32'h0000_0100);
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        #1;
        chk(m0_ready && m0_rdata == 32'h1234_5678, "d_m0_read", m0_rdata, 32'h1234_5678);
        chk(!m1_ready, "d_m1_idle", {31'b0, m1_ready}, 32'h0);
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        mem_ready = 1'b0;

        // m1 write, then reset lands mid-grant.
        rv[1] = 1'b1; r_addr[1] = 32'h8000_0010; r_wdata[1] = 32'hCAFE_F00D; r_wstrb[1] = 4'b0011;
        wait_grant(got);
        chk(got && mem_addr == 32'h8000_0010, "d_m1_addr", mem_addr, 32'h8000_0010);
        chk(mem_wdata == 32'hCAFE_F00D, "d_m1_wdata", mem_wdata, 32'hCAFE_F00D);
        chk(mem_wstrb == 4'b0011, "d_m1_wstrb", {28'b0, mem_wstrb}, 32'h3);
        mem_ready = 1'b1;
        reset = 1'b1;
        #1;
        chk(!mem_valid, "d_rst_mem_valid", {31'b0, mem_valid}, 32'h0);
        chk(!m1_ready, "d_rst_m1_ready", {31'b0, m1_ready}, 32'h0);
        chk(!timeout_err, "d_rst_timeout_err", {31'b0, timeout_err}, 32'h0);
        chk(mem_wstrb == 4'h0, "d_rst_wstrb", {28'b0, mem_wstrb}, 32'h0);
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rv[0] = 1'b1; r_addr[0] = 32'h0000_0200;
        wait_grant(got);
        chk(got && mem_addr == 32'h0000_0200, "d_tie_after_reset", mem_addr, 32'h0000_0200);
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        #1;
        chk(m0_ready && !m1_ready && m0_rdata == 32'h0BAD_F00D, "d_tie_complete", m0_rdata, 32'h0BAD_F00D);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got time %0t expected completion before it", $time);
        $fatal(1, "bench did not complete");
    end

endmodule
